// File: rtl/led_status_ctrl.sv
// led_status_ctrl: multi-channel LED indicator engine.
// Each channel runs off / on / blink / activity (pulse-stretched flicker) from a
// shared free-running tick prescaler. Outputs are registered for direct pin drive.
// Optional feature macro: LED_PWM_EN adds a global 8-bit PWM brightness gate
// using the per-channel duty field; without it duty is accepted but has no effect.
module led_status_ctrl #(
    parameter int CHANNELS     = 4,
    parameter int PRESCALE     = 125000,
    parameter int PERIOD_WIDTH = 16,
    parameter int STRETCH      = 50
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [2*CHANNELS-1:0]            mode,
    input  logic [PERIOD_WIDTH*CHANNELS-1:0] half_period,
    input  logic [CHANNELS-1:0]              act,
    input  logic [8*CHANNELS-1:0]            duty,
    output logic                             tick_o,
    output logic [CHANNELS-1:0]              led_o
);

    localparam int PS_W  = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int ST_W  = (STRETCH > 1) ? $clog2(STRETCH + 1) : 1;
    localparam int CNT_W = (PERIOD_WIDTH > ST_W) ? PERIOD_WIDTH : ST_W;

    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_ACT   = 2'b11;

    typedef enum logic [1:0] {
        ACT_IDLE = 2'b00,
        ACT_OFF  = 2'b01,
        ACT_ON   = 2'b10
    } act_state_t;

    logic [PS_W-1:0]     presc_r;
    logic [PS_W-1:0]     presc_nxt_s;
    logic                tick_r;
    logic [CHANNELS-1:0] led_r;
    logic [CHANNELS-1:0] mask_s;
    wire  [CHANNELS-1:0] raw_all_s;

    // Next prescaler value: count up and wrap at PRESCALE-1
    always_comb begin
        if (presc_r == PS_LAST) begin
            presc_nxt_s = '0;
        end else begin
            presc_nxt_s = presc_r + PS_ONE;
        end
    end

    // Prescaler and tick register; tick_r is high exactly while presc_r sits at its last value
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
            tick_r  <= 1'b0;
        end else begin
            presc_r <= presc_nxt_s;
            tick_r  <= (presc_nxt_s == PS_LAST);
        end
    end

    assign tick_o = tick_r;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [1:0]              mode_s;
        logic [PERIOD_WIDTH-1:0] hp_s;
        logic                    act_s;
        logic [CNT_W-1:0]        hp_last_s;
        logic                    raw_s;
        logic [1:0]              mode_q_r;
        logic [CNT_W-1:0]        cnt_r;
        logic                    phase_r;
        act_state_t              act_st_r;

        assign mode_s = mode[2*c +: 2];
        assign hp_s   = half_period[PERIOD_WIDTH*c +: PERIOD_WIDTH];
        assign act_s  = act[c];

        // Terminal blink count; a zero half-period behaves as one tick
        always_comb begin
            if (hp_s == '0) begin
                hp_last_s = '0;
            end else begin
                hp_last_s = CNT_W'(hp_s) - CNT_ONE;
            end
        end

        // Channel state: mode tracking, blink counter/phase and activity FSM; a mode change restarts everything
        always_ff @(posedge clk) begin
            if (rst) begin
                mode_q_r <= MODE_OFF;
                cnt_r    <= '0;
                phase_r  <= 1'b1;
                act_st_r <= ACT_IDLE;
            end else begin
                mode_q_r <= mode_s;
                if (mode_s != mode_q_r) begin
                    cnt_r    <= '0;
                    phase_r  <= 1'b1;
                    act_st_r <= ACT_IDLE;
                end else begin
                    case (mode_q_r)
                        MODE_BLINK: begin
                            if (tick_r) begin
                                if (cnt_r >= hp_last_s) begin
                                    cnt_r   <= '0;
                                    phase_r <= ~phase_r;
                                end else begin
                                    cnt_r <= cnt_r + CNT_ONE;
                                end
                            end
                        end
                        MODE_ACT: begin
                            case (act_st_r)
                                ACT_IDLE: begin
                                    if (act_s) begin
                                        act_st_r <= ACT_OFF;
                                        cnt_r    <= '0;
                                    end
                                end
                                ACT_OFF: begin
                                    if (tick_r) begin
                                        if (cnt_r >= ST_LAST) begin
                                            act_st_r <= ACT_ON;
                                            cnt_r    <= '0;
                                        end else begin
                                            cnt_r <= cnt_r + CNT_ONE;
                                        end
                                    end
                                end
                                ACT_ON: begin
                                    if (tick_r) begin
                                        if (cnt_r >= ST_LAST) begin
                                            act_st_r <= ACT_IDLE;
                                            cnt_r    <= '0;
                                        end else begin
                                            cnt_r <= cnt_r + CNT_ONE;
                                        end
                                    end
                                end
                                default: begin
                                    act_st_r <= ACT_IDLE;
                                    cnt_r    <= '0;
                                end
                            endcase
                        end
                        default: begin
                            cnt_r <= cnt_r;
                        end
                    endcase
                end
            end
        end

        // Raw LED level from the registered channel state
        always_comb begin
            case (mode_q_r)
                MODE_OFF:   raw_s = 1'b0;
                MODE_ON:    raw_s = 1'b1;
                MODE_BLINK: raw_s = phase_r;
                MODE_ACT:   raw_s = (act_st_r != ACT_OFF);
                default:    raw_s = 1'b0;
            endcase
        end

        assign raw_all_s[c] = raw_s;
    end

`ifdef LED_PWM_EN
    logic [7:0] pwm_cnt_r;

    // Free-running PWM phase counter shared by all channels
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_r <= 8'd0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + 8'd1;
        end
    end

    // Per-channel brightness gate: lit while the PWM phase is below duty
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (pwm_cnt_r < duty[8*i +: 8]) begin
                mask_s[i] = 1'b1;
            end else begin
                mask_s[i] = 1'b0;
            end
        end
    end
`else
    // Full brightness; duty is folded into an always-true mask so the port stays connected
    always_comb begin
        mask_s = {CHANNELS{1'b1}} | {CHANNELS{^duty}};
    end
`endif

    // Registered LED drive
    always_ff @(posedge clk) begin
        if (rst) begin
            led_r <= '0;
        end else begin
            led_r <= raw_all_s & mask_s;
        end
    end

    assign led_o = led_r;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Testbench for led_status_ctrl (CHANNELS=2, PRESCALE=4, STRETCH=3).
// Directed scenarios followed by randomized stimulus, all checked every cycle
// against a tick/time-based behavioural model of the LED rules.
module tb_led_status_ctrl;

    localparam int CH = 2;
    localparam int PS = 4;
    localparam int PW = 4;
    localparam int ST = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [2*CH-1:0]   mode;
    logic [PW*CH-1:0]  half_period;
    logic [CH-1:0]     act;
    logic [8*CH-1:0]   duty;
    logic              tick_o;
    logic [CH-1:0]     led_o;

    int total = 0;
    int bad   = 0;

    // Model state: cycles since reset, per-channel last mode, blink level,
    // ticks spent in current blink phase, ticks since accepted activity (-1 = none)
    int          m_cyc;
    int          m_mode [CH];
    int          m_lit  [CH];
    int          m_el   [CH];
    int          m_act  [CH];
    logic [CH-1:0] exp_led;
    logic        exp_tick;

    led_status_ctrl #(
        .CHANNELS(CH), .PRESCALE(PS), .PERIOD_WIDTH(PW), .STRETCH(ST)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .half_period(half_period),
        .act(act), .duty(duty), .tick_o(tick_o), .led_o(led_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model over one rising edge using the inputs present at that edge
    task automatic model_step();
        bit tk;
        int hp;
        int md;
        bit lvl;
        if (rst) begin
            m_cyc = 0;
            for (int c = 0; c < CH; c++) begin
                m_mode[c] = 0; m_lit[c] = 1; m_el[c] = 0; m_act[c] = -1;
            end
            exp_led  = '0;
            exp_tick = 1'b0;
            return;
        end
        tk = ((m_cyc % PS) == PS - 1);
        for (int c = 0; c < CH; c++) begin
            md = int'(mode[2*c +: 2]);
            hp = int'(half_period[PW*c +: PW]);
            if (hp < 1) hp = 1;
            case (m_mode[c])
                0: lvl = 1'b0;
                1: lvl = 1'b1;
                2: lvl = m_lit[c][0];
                default: lvl = !(m_act[c] >= 0 && m_act[c] < ST);
            endcase
`ifdef LED_PWM_EN
            lvl = lvl && ((m_cyc % 256) < int'(duty[8*c +: 8]));
`endif
            exp_led[c] = lvl;
            if (md != m_mode[c]) begin
                m_lit[c] = 1; m_el[c] = 0; m_act[c] = -1;
            end else if (md == 2) begin
                if (tk) begin
                    m_el[c]++;
                    if (m_el[c] >= hp) begin
                        m_lit[c] = 1 - m_lit[c];
                        m_el[c]  = 0;
                    end
                end
            end else if (md == 3) begin
                if (m_act[c] < 0) begin
                    if (act[c]) m_act[c] = 0;
                end else if (tk) begin
                    m_act[c]++;
                    if (m_act[c] >= 2 * ST) m_act[c] = -1;
                end
            end
            m_mode[c] = md;
        end
        m_cyc++;
        exp_tick = ((m_cyc % PS) == PS - 1);
    endtask

    // One clock: model update at the edge, compare on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("led", 32'(led_o), 32'(exp_led));
        check("tick", 32'(tick_o), 32'(exp_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; mode = 4'b0101; half_period = '0; act = '0;
`ifdef LED_PWM_EN
        duty = {8'd0, 8'd64};
`else
        duty = {8'd200, 8'd17};
`endif
        @(negedge clk);
        run(5);
        rst = 1'b0;
        run(1);
`ifndef LED_PWM_EN
        cycle();
        check("rst_release_led0", 32'(led_o[0]), 32'd1);
`endif
        // blink with half_period=2, then 0 (treated as 1)
        mode = 4'b0110; half_period = {4'd0, 4'd2};
        run(40);
        half_period = {4'd0, 4'd0};
        run(20);
        // mid-blink mode bounce 10->01->10
        half_period = {4'd0, 4'd2};
        run(13);
        mode = 4'b0101; run(1);
        mode = 4'b0110; run(20);
        // activity on ch1 with a retrigger attempt during the off phase
        mode = 4'b1110; run(3);
        act = 2'b10; run(1);
        act = 2'b00; run(4);
        act = 2'b10; run(1);
        act = 2'b00; run(30);
        // continuous traffic plus a simultaneous act/mode change
        act = 2'b11; mode = 4'b1111; run(40);
        mode = 4'b0011; run(6);
        act = 2'b00; run(5);
        // randomized stimulus
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(19, 0) == 0) mode[2*c +: 2] = 2'($urandom_range(3, 0));
                if ($urandom_range(29, 0) == 0) half_period[PW*c +: PW] = 4'($urandom_range(3, 0));
                if ($urandom_range(99, 0) == 0) duty[8*c +: 8] = 8'($urandom_range(255, 0));
                act[c] = ($urandom_range(3, 0) == 0);
            end
            rst = ($urandom_range(599, 0) == 0);
            cycle();
        end
        rst = 1'b0;
        run(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
